// File: rtl/cpu_pkg.sv
// Shared CPU definitions: next-PC select codes, fetch FSM states, default widths.
package cpu_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 16;
    localparam int unsigned INSTR_WIDTH    = 16;
    localparam int unsigned DISP_WIDTH     = 8;

    // Next-PC select driven by the control FSM alongside PCEn
    typedef enum logic [1:0] {
        PC_INC  = 2'b00,
        PC_BR   = 2'b01,
        PC_JMP  = 2'b10,
        PC_HOLD = 2'b11
    } pc_state_e;

    // Instruction fetch sequencer states
    typedef enum logic [1:0] {
        FETCH_S   = 2'b00,
        CAPTURE_S = 2'b01,
        HOLD_S    = 2'b10
    } fetch_state_e;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection: increment, PC-relative branch, register jump or hold.
module pc_next_calc
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic [ADDR_WIDTH-1:0]  pc_i,
    input  pc_state_e              pc_state_i,
    input  logic [DISP_WIDTH-1:0]  disp_i,
    input  logic [15:0]            jump_target_i,
    output logic [ADDR_WIDTH-1:0]  pc_next_o,
    output logic [ADDR_WIDTH-1:0]  pc_plus1_o
);

    logic [ADDR_WIDTH-1:0] disp_ext;
    logic [ADDR_WIDTH-1:0] jump_ext;

    // Branch displacement is relative to the current PC, not PC+1; all sums wrap
    always_comb begin
        disp_ext   = {{(ADDR_WIDTH-DISP_WIDTH){disp_i[DISP_WIDTH-1]}}, disp_i};
        jump_ext   = ADDR_WIDTH'(jump_target_i);
        pc_plus1_o = pc_i + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        pc_next_o  = pc_i;
        unique case (pc_state_i)
            PC_INC:  pc_next_o = pc_plus1_o;
            PC_BR:   pc_next_o = pc_i + disp_ext;
            PC_JMP:  pc_next_o = jump_ext;
            PC_HOLD: pc_next_o = pc_i;
            default: pc_next_o = pc_i;
        endcase
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads synchronous instruction RAM and
// presents a held instruction word to the control FSM.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH   = ADDR_WIDTH_DEF,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic                    PCEn,
    input  logic [1:0]              PCState,
    input  logic [DISP_WIDTH-1:0]   Disp,
    input  logic [15:0]             JumpTarget,
    input  logic                    MemBusy,
    input  logic [INSTR_WIDTH-1:0]  MemData,
    output logic [ADDR_WIDTH-1:0]   MemAddr,
    output logic                    MemRdEn,
    output logic [ADDR_WIDTH-1:0]   PC,
    output logic [ADDR_WIDTH-1:0]   PCPlus1,
    output logic [INSTR_WIDTH-1:0]  Instr,
    output logic                    InstrValid
);

    fetch_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] ir_q, ir_d;
    logic [ADDR_WIDTH-1:0]  pc_next;
    logic [ADDR_WIDTH-1:0]  pc_plus1;
    logic                   rd_en;

    pc_next_calc #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_pc_next_calc (
        .pc_i          (pc_q),
        .pc_state_i    (pc_state_e'(PCState)),
        .disp_i        (Disp),
        .jump_target_i (JumpTarget),
        .pc_next_o     (pc_next),
        .pc_plus1_o    (pc_plus1)
    );

    // State, PC and instruction register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= FETCH_S;
            pc_q    <= RESET_VECTOR;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // Fetch sequencing; PCEn is only honoured once the word is held
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        rd_en   = 1'b0;
        unique case (state_q)
            FETCH_S: begin
                if (!MemBusy) begin
                    rd_en   = 1'b1;
                    state_d = CAPTURE_S;
                end
            end
            CAPTURE_S: begin
                ir_d    = MemData;
                state_d = HOLD_S;
            end
            HOLD_S: begin
                if (PCEn) begin
                    pc_d    = pc_next;
                    state_d = FETCH_S;
                end
            end
            default: state_d = FETCH_S;
        endcase
    end

    // Read strobe is masked by reset so no request escapes while Reset_n is low
    always_comb begin
        MemRdEn    = rd_en & Reset_n;
        MemAddr    = pc_q;
        PC         = pc_q;
        PCPlus1    = pc_plus1;
        Instr      = ir_q;
        InstrValid = (state_q == HOLD_S);
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit with a synchronous RAM model and
// an expected-instruction scoreboard.
module tb_instr_fetch_unit;

    localparam logic [15:0] RV = 16'h0000;
    localparam logic [1:0]  S_INC = 2'b00, S_BR = 2'b01, S_JMP = 2'b10, S_HOLD = 2'b11;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        PCEn = 1'b0;
    logic [1:0]  PCState = 2'b00;
    logic [7:0]  Disp = 8'h00;
    logic [15:0] JumpTarget = 16'h0000;
    logic        MemBusy = 1'b0;
    logic [15:0] MemData = 16'h0000;
    logic [15:0] MemAddr;
    logic        MemRdEn;
    logic [15:0] PC;
    logic [15:0] PCPlus1;
    logic [15:0] Instr;
    logic        InstrValid;

    instr_fetch_unit #(
        .ADDR_WIDTH   (16),
        .RESET_VECTOR (RV)
    ) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .PCEn       (PCEn),
        .PCState    (PCState),
        .Disp       (Disp),
        .JumpTarget (JumpTarget),
        .MemBusy    (MemBusy),
        .MemData    (MemData),
        .MemAddr    (MemAddr),
        .MemRdEn    (MemRdEn),
        .PC         (PC),
        .PCPlus1    (PCPlus1),
        .Instr      (Instr),
        .InstrValid (InstrValid)
    );

    always #5 Clk = ~Clk;

    // Synchronous-read instruction RAM
    logic [15:0] ram [0:65535];
    always @(posedge Clk) begin
        if (MemRdEn) MemData <= ram[MemAddr];
    end

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] instr;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] model_pc;
    int          n;

    function automatic logic [15:0] model_next(input logic [15:0] pc, input logic [1:0] st,
                                               input logic [7:0] d, input logic [15:0] jt);
        logic [15:0] sx;
        sx = {{8{d[7]}}, d};
        case (st)
            S_INC:   return pc + 16'd1;
            S_BR:    return pc + sx;
            S_JMP:   return jt;
            default: return pc;
        endcase
    endfunction

    // Drive a command at a HOLD negedge; returns at the following negedge (FETCH)
    task automatic issue(input logic [1:0] st, input logic [7:0] d, input logic [15:0] jt,
                         input logic busy);
        PCEn = 1'b1; PCState = st; Disp = d; JumpTarget = jt; MemBusy = busy;
        model_pc = model_next(model_pc, st, d, jt);
        sb.push_back('{pc: model_pc, instr: ram[model_pc]});
        @(negedge Clk);
        PCEn = 1'b0;
    endtask

    // Counts negedges until InstrValid; -1 if the bound expires
    task automatic wait_hold(output int cnt);
        cnt = 0;
        while (InstrValid !== 1'b1 && cnt < 64) begin
            @(negedge Clk);
            cnt++;
        end
        if (InstrValid !== 1'b1) cnt = -1;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0; MemBusy = 1'b0;
        @(negedge Clk); @(negedge Clk);
        vectors++; if (PC !== RV) begin miscompares++; $display("FAIL reset_pc got=%h exp=%h", PC, RV); end
        vectors++; if (Instr !== 16'h0000) begin miscompares++; $display("FAIL reset_ir got=%h exp=0000", Instr); end
        vectors++; if (InstrValid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%b exp=0", InstrValid); end
        vectors++; if (MemRdEn !== 1'b0) begin miscompares++; $display("FAIL reset_rden got=%b exp=0", MemRdEn); end
        Reset_n = 1'b1;
        model_pc = RV;
        sb.push_back('{pc: RV, instr: 16'h1234});
        #1;
        vectors++; if (MemRdEn !== 1'b1) begin miscompares++; $display("FAIL release_rden got=%b exp=1", MemRdEn); end
        vectors++; if (MemAddr !== RV) begin miscompares++; $display("FAIL release_addr got=%h exp=%h", MemAddr, RV); end
        wait_hold(n);
        vectors++; if (n !== 2) begin miscompares++; $display("FAIL first_latency got=%0d exp=2", n); end
        e = sb.pop_front();
        vectors++; if (Instr !== e.instr) begin miscompares++; $display("FAIL first_instr got=%h exp=%h", Instr, e.instr); end
        vectors++; if (PC !== e.pc) begin miscompares++; $display("FAIL first_pc got=%h exp=%h", PC, e.pc); end
    endtask

    task automatic test_hold_stable();
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            vectors++; if (InstrValid !== 1'b1 || Instr !== e.instr) begin
                miscompares++; $display("FAIL hold_stable got=%b/%h exp=1/%h", InstrValid, Instr, e.instr);
            end
        end
    endtask

    task automatic test_branch();
        issue(S_JMP, 8'h00, 16'h0010, 1'b0);
        vectors++; if (InstrValid !== 1'b0) begin miscompares++; $display("FAIL valid_drop got=%b exp=0", InstrValid); end
        vectors++; if (PC !== 16'h0010) begin miscompares++; $display("FAIL jmp_pc got=%h exp=0010", PC); end
        wait_hold(n);
        e = sb.pop_front();
        vectors++; if (Instr !== e.instr) begin miscompares++; $display("FAIL jmp_instr got=%h exp=%h", Instr, e.instr); end
        issue(S_BR, 8'hFC, 16'h0000, 1'b0);
        vectors++; if (PC !== 16'h000C) begin miscompares++; $display("FAIL br_back_pc got=%h exp=000C", PC); end
        vectors++; if (MemRdEn !== 1'b1 || MemAddr !== 16'h000C) begin
            miscompares++; $display("FAIL br_back_fetch got=%b/%h exp=1/000C", MemRdEn, MemAddr);
        end
        wait_hold(n);
        vectors++; if (n !== 2) begin miscompares++; $display("FAIL cmd_latency got=%0d exp=2", n); end
        e = sb.pop_front();
        vectors++; if (Instr !== e.instr) begin miscompares++; $display("FAIL br_instr got=%h exp=%h", Instr, e.instr); end
    endtask

    task automatic test_wrap();
        issue(S_JMP, 8'h00, 16'hFFFF, 1'b0);
        wait_hold(n);
        e = sb.pop_front();
        vectors++; if (Instr !== e.instr) begin miscompares++; $display("FAIL ffff_instr got=%h exp=%h", Instr, e.instr); end
        issue(S_INC, 8'h00, 16'h0000, 1'b0);
        vectors++; if (PC !== 16'h0000) begin miscompares++; $display("FAIL inc_wrap_pc got=%h exp=0000", PC); end
        wait_hold(n);
        e = sb.pop_front();
        vectors++; if (Instr !== e.instr) begin miscompares++; $display("FAIL wrap_instr got=%h exp=%h", Instr, e.instr); end
        issue(S_JMP, 8'h00, 16'h0400, 1'b0);
        vectors++; if (PC !== 16'h0400) begin miscompares++; $display("FAIL jmp400_pc got=%h exp=0400", PC); end
        vectors++; if (PCPlus1 !== 16'h0401) begin miscompares++; $display("FAIL pcplus1 got=%h exp=0401", PCPlus1); end
        wait_hold(n);
        e = sb.pop_front();
        vectors++; if (Instr !== e.instr) begin miscompares++; $display("FAIL jmp400_instr got=%h exp=%h", Instr, e.instr); end
        issue(S_JMP, 8'h00, 16'h0000, 1'b0);
        wait_hold(n);
        e = sb.pop_front();
        issue(S_BR, 8'h80, 16'h0000, 1'b0);
        vectors++; if (PC !== 16'hFF80) begin miscompares++; $display("FAIL br_neg_wrap_pc got=%h exp=FF80", PC); end
        wait_hold(n);
        e = sb.pop_front();
        vectors++; if (Instr !== e.instr) begin miscompares++; $display("FAIL ff80_instr got=%h exp=%h", Instr, e.instr); end
    endtask

    task automatic test_refetch();
        ram[model_pc] = 16'hBEEF;
        issue(S_HOLD, 8'h00, 16'h0000, 1'b0);
        vectors++; if (PC !== 16'hFF80) begin miscompares++; $display("FAIL refetch_pc got=%h exp=FF80", PC); end
        wait_hold(n);
        e = sb.pop_front();
        vectors++; if (Instr !== 16'hBEEF || e.instr !== 16'hBEEF) begin
            miscompares++; $display("FAIL refetch_instr got=%h exp=BEEF", Instr);
        end
    endtask

    task automatic test_membusy();
        issue(S_INC, 8'h00, 16'h0000, 1'b1);
        for (int i = 0; i < 3; i++) begin
            vectors++; if (MemRdEn !== 1'b0 || InstrValid !== 1'b0) begin
                miscompares++; $display("FAIL busy_stall cyc=%0d got=%b/%b exp=0/0", i, MemRdEn, InstrValid);
            end
            vectors++; if (PC !== model_pc) begin miscompares++; $display("FAIL busy_pc got=%h exp=%h", PC, model_pc); end
            @(negedge Clk);
        end
        MemBusy = 1'b0;
        wait_hold(n);
        if (n >= 0) n = n + 3;
        vectors++; if (n !== 5) begin miscompares++; $display("FAIL busy_latency got=%0d exp=5", n); end
        e = sb.pop_front();
        vectors++; if (Instr !== e.instr) begin miscompares++; $display("FAIL busy_instr got=%h exp=%h", Instr, e.instr); end
    endtask

    task automatic test_capture_ignore();
        issue(S_INC, 8'h00, 16'h0000, 1'b0);
        @(negedge Clk);
        vectors++; if (InstrValid !== 1'b0) begin miscompares++; $display("FAIL capture_valid got=%b exp=0", InstrValid); end
        PCEn = 1'b1; PCState = S_JMP; JumpTarget = 16'h7777; MemBusy = 1'b1;
        @(negedge Clk);
        PCEn = 1'b0; MemBusy = 1'b0;
        vectors++; if (InstrValid !== 1'b1) begin miscompares++; $display("FAIL capture_busy_valid got=%b exp=1", InstrValid); end
        vectors++; if (PC !== model_pc) begin miscompares++; $display("FAIL capture_pcen_pc got=%h exp=%h", PC, model_pc); end
        e = sb.pop_front();
        vectors++; if (Instr !== e.instr) begin miscompares++; $display("FAIL capture_instr got=%h exp=%h", Instr, e.instr); end
    endtask

    task automatic test_reset_capture();
        issue(S_INC, 8'h00, 16'h0000, 1'b0);
        @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        vectors++; if (InstrValid !== 1'b0) begin miscompares++; $display("FAIL midrst_valid got=%b exp=0", InstrValid); end
        vectors++; if (PC !== RV) begin miscompares++; $display("FAIL midrst_pc got=%h exp=%h", PC, RV); end
        vectors++; if (MemRdEn !== 1'b0) begin miscompares++; $display("FAIL midrst_rden got=%b exp=0", MemRdEn); end
        sb.delete();
        @(negedge Clk);
        Reset_n = 1'b1;
        model_pc = RV;
        sb.push_back('{pc: RV, instr: ram[RV]});
        wait_hold(n);
        vectors++; if (n !== 2) begin miscompares++; $display("FAIL midrst_latency got=%0d exp=2", n); end
        e = sb.pop_front();
        vectors++; if (Instr !== e.instr) begin miscompares++; $display("FAIL midrst_instr got=%h exp=%h", Instr, e.instr); end
        vectors++; if (PC !== e.pc) begin miscompares++; $display("FAIL midrst_refetch_pc got=%h exp=%h", PC, e.pc); end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = 16'((i * 7) ^ 32'h5A5A);
        ram[0] = 16'h1234;
        test_reset();
        test_hold_stable();
        test_branch();
        test_wrap();
        test_refetch();
        test_membusy();
        test_capture_ignore();
        test_reset_capture();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
